// File: rtl/addr_slot_arbiter_if.sv
// addr_slot_arbiter_if: request/grant bundle between master address-control blocks, arbiter and address mux
interface addr_slot_arbiter_if #(
    parameter int NUM_MASTERS       = 4,
    parameter int NUM_MASTERS_WIDTH = 2,
    parameter int NUM_SLAVES_WIDTH  = 2
);
    logic [NUM_MASTERS-1:0]                  reqValidQual;
    logic [NUM_MASTERS*NUM_SLAVES_WIDTH-1:0] reqSlaveID;
    logic                                    slotReady;
    logic                                    grantValid;
    logic [NUM_MASTERS-1:0]                  grantOneHot;
    logic [NUM_MASTERS_WIDTH-1:0]            grantMasterNum;
    logic [NUM_SLAVES_WIDTH-1:0]             grantSlaveID;
    logic [NUM_MASTERS-1:0]                  openTransInc;

    modport slave (
        input  reqValidQual, reqSlaveID, slotReady,
        output grantValid, grantOneHot, grantMasterNum, grantSlaveID, openTransInc
    );

    modport master (
        output reqValidQual, reqSlaveID, slotReady,
        input  grantValid, grantOneHot, grantMasterNum, grantSlaveID, openTransInc
    );
endinterface

// File: rtl/addr_slot_arbiter.sv
// addr_slot_arbiter: round-robin master arbiter presenting one registered master/slave grant at a time
// to the crossbar address mux, pulsing openTransInc back to the master on each accepted handshake.
module addr_slot_arbiter #(
    parameter int NUM_MASTERS       = 4,
    parameter int NUM_MASTERS_WIDTH = 2,
    parameter int NUM_SLAVES_WIDTH  = 2
) (
    input logic                sysClk,
    input logic                sysReset,
    addr_slot_arbiter_if.slave bus
);
    localparam int MW = NUM_MASTERS_WIDTH;
    localparam int SW = NUM_SLAVES_WIDTH;

    typedef enum logic [1:0] {IDLE, GRANT, SETTLE} state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          last_grant_q, last_grant_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [NUM_MASTERS-1:0] grant_one_hot_q, grant_one_hot_d;
    logic [MW-1:0]          grant_master_q, grant_master_d;
    logic [SW-1:0]          grant_slave_q, grant_slave_d;
    logic [NUM_MASTERS-1:0] open_inc_q, open_inc_d;

    logic [SW-1:0] slave_id [NUM_MASTERS];
    logic [MW-1:0] winner;
    logic [MW-1:0] idx;
    logic          found;

    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_slice
        assign slave_id[g] = bus.reqSlaveID[g*SW +: SW];
    end

    // Scan from the farthest candidate down so the one nearest lastGrant+1 overwrites the rest.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = MW'((int'(last_grant_q) + i) % NUM_MASTERS);
            if (bus.reqValidQual[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        last_grant_d    = last_grant_q;
        grant_valid_d   = grant_valid_q;
        grant_one_hot_d = grant_one_hot_q;
        grant_master_d  = grant_master_q;
        grant_slave_d   = grant_slave_q;
        open_inc_d      = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d         = GRANT;
                    grant_valid_d   = 1'b1;
                    grant_one_hot_d = NUM_MASTERS'(1) << winner;
                    grant_master_d  = winner;
                    grant_slave_d   = slave_id[winner];
                end
            end
            GRANT: begin
                // slotReady alone completes the handshake, so a same-cycle withdrawal still counts.
                if (bus.slotReady) begin
                    state_d         = SETTLE;
                    grant_valid_d   = 1'b0;
                    grant_one_hot_d = '0;
                    open_inc_d      = grant_one_hot_q;
                    last_grant_d    = grant_master_q;
                end else if (!bus.reqValidQual[grant_master_q]) begin
                    state_d         = IDLE;
                    grant_valid_d   = 1'b0;
                    grant_one_hot_d = '0;
                end
            end
            SETTLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge sysReset) begin
        if (!sysReset) begin
            state_q         <= IDLE;
            last_grant_q    <= MW'(NUM_MASTERS - 1);
            grant_valid_q   <= 1'b0;
            grant_one_hot_q <= '0;
            grant_master_q  <= '0;
            grant_slave_q   <= '0;
            open_inc_q      <= '0;
        end else begin
            state_q         <= state_d;
            last_grant_q    <= last_grant_d;
            grant_valid_q   <= grant_valid_d;
            grant_one_hot_q <= grant_one_hot_d;
            grant_master_q  <= grant_master_d;
            grant_slave_q   <= grant_slave_d;
            open_inc_q      <= open_inc_d;
        end
    end

    assign bus.grantValid     = grant_valid_q;
    assign bus.grantOneHot    = grant_one_hot_q;
    assign bus.grantMasterNum = grant_master_q;
    assign bus.grantSlaveID   = grant_slave_q;
    assign bus.openTransInc   = open_inc_q;
endmodule

// File: tb/tb_addr_slot_arbiter.sv
// tb_addr_slot_arbiter: directed vector table plus hand-written corner sequences for addr_slot_arbiter.
module tb_addr_slot_arbiter;
    typedef struct packed {
        logic [3:0] req;
        logic [7:0] sid;
        logic       rdy;
        logic       v;
        logic [3:0] oh;
        logic [1:0] mn;
        logic [1:0] sl;
        logic [3:0] inc;
    } vec_t;

    logic sysClk;
    logic sysReset;
    int   n_cmp;
    int   n_bad;
    vec_t vecs [32];

    addr_slot_arbiter_if #(.NUM_MASTERS(4), .NUM_MASTERS_WIDTH(2), .NUM_SLAVES_WIDTH(2)) bus ();

    addr_slot_arbiter #(.NUM_MASTERS(4), .NUM_MASTERS_WIDTH(2), .NUM_SLAVES_WIDTH(2)) dut (
        .sysClk   (sysClk),
        .sysReset (sysReset),
        .bus      (bus)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    function automatic logic [12:0] outs();
        return {bus.grantValid, bus.grantOneHot, bus.grantMasterNum, bus.grantSlaveID, bus.openTransInc};
    endfunction

    // Master/slave fields are only meaningful while a grant is presented.
    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] care;
        care = exp[12] ? 13'h1FFF : 13'h1F0F;
        n_cmp++;
        if ((outs() & care) !== (exp & care)) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (care %b)", name, outs(), exp, care);
        end
    endtask

    task automatic step(input string name, input logic [3:0] req, input logic [7:0] sid,
                        input logic rdy, input logic [12:0] exp);
        bus.reqValidQual = req;
        bus.reqSlaveID   = sid;
        bus.slotReady    = rdy;
        @(posedge sysClk);
        #1;
        check(name, exp);
        n_cmp++;
        if (!$onehot0(bus.grantOneHot) || !$onehot0(bus.openTransInc)) begin
            n_bad++;
            $display("FAIL %s_onehot: grantOneHot %b openTransInc %b", name, bus.grantOneHot, bus.openTransInc);
        end
    endtask

    task automatic do_reset();
        sysReset         = 1'b0;
        bus.reqValidQual = '0;
        bus.reqSlaveID   = '0;
        bus.slotReady    = 1'b0;
        repeat (2) @(posedge sysClk);
        #1;
        check("reset", 13'h0000);
        sysReset = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        // All four requesting: m0..m3 then m0 again, one grant every 3 cycles.
        vecs[0]  = {4'hF, 8'hE4, 1'b1, 1'b1, 4'b0001, 2'd0, 2'd0, 4'b0000};
        vecs[1]  = {4'hF, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0001};
        vecs[2]  = {4'hF, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};
        vecs[3]  = {4'hF, 8'hE4, 1'b1, 1'b1, 4'b0010, 2'd1, 2'd1, 4'b0000};
        vecs[4]  = {4'hF, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0010};
        vecs[5]  = {4'hF, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};
        vecs[6]  = {4'hF, 8'hE4, 1'b1, 1'b1, 4'b0100, 2'd2, 2'd2, 4'b0000};
        vecs[7]  = {4'hF, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0100};
        vecs[8]  = {4'hF, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};
        vecs[9]  = {4'hF, 8'hE4, 1'b1, 1'b1, 4'b1000, 2'd3, 2'd3, 4'b0000};
        vecs[10] = {4'hF, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b1000};
        vecs[11] = {4'hF, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};
        vecs[12] = {4'hF, 8'hE4, 1'b1, 1'b1, 4'b0001, 2'd0, 2'd0, 4'b0000};
        // m0 withdraws, then m2 alone targeting slave 3 is held 6 cycles before acceptance.
        vecs[13] = {4'h4, 8'h30, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};
        vecs[14] = {4'h4, 8'h30, 1'b0, 1'b1, 4'b0100, 2'd2, 2'd3, 4'b0000};
        vecs[15] = {4'h4, 8'h30, 1'b0, 1'b1, 4'b0100, 2'd2, 2'd3, 4'b0000};
        vecs[16] = {4'h4, 8'h30, 1'b0, 1'b1, 4'b0100, 2'd2, 2'd3, 4'b0000};
        vecs[17] = {4'h4, 8'h30, 1'b0, 1'b1, 4'b0100, 2'd2, 2'd3, 4'b0000};
        vecs[18] = {4'h4, 8'h30, 1'b0, 1'b1, 4'b0100, 2'd2, 2'd3, 4'b0000};
        vecs[19] = {4'h4, 8'h30, 1'b0, 1'b1, 4'b0100, 2'd2, 2'd3, 4'b0000};
        vecs[20] = {4'h4, 8'h30, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0100};
        vecs[21] = {4'h0, 8'h30, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};
        vecs[22] = {4'h0, 8'h30, 1'b0, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};
        // m3 granted, then 1001 wraps to m0 before m3.
        vecs[23] = {4'h8, 8'hE4, 1'b1, 1'b1, 4'b1000, 2'd3, 2'd3, 4'b0000};
        vecs[24] = {4'h8, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b1000};
        vecs[25] = {4'h9, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};
        vecs[26] = {4'h9, 8'hE4, 1'b1, 1'b1, 4'b0001, 2'd0, 2'd0, 4'b0000};
        vecs[27] = {4'h9, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0001};
        vecs[28] = {4'h9, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};
        vecs[29] = {4'h9, 8'hE4, 1'b1, 1'b1, 4'b1000, 2'd3, 2'd3, 4'b0000};
        vecs[30] = {4'h0, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b1000};
        vecs[31] = {4'h0, 8'hE4, 1'b1, 1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000};

        do_reset();
        for (int i = 0; i < 32; i++) begin
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].sid, vecs[i].rdy,
                 {vecs[i].v, vecs[i].oh, vecs[i].mn, vecs[i].sl, vecs[i].inc});
        end

        // Withdrawal leaves the pointer alone; m1 beats m3 on re-request.
        do_reset();
        step("wd_grant",   4'b0010, 8'hE4, 1'b0, {1'b1, 4'b0010, 2'd1, 2'd1, 4'b0000});
        step("wd_hold",    4'b0010, 8'hE4, 1'b0, {1'b1, 4'b0010, 2'd1, 2'd1, 4'b0000});
        step("wd_drop",    4'b0000, 8'hE4, 1'b0, {1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000});
        step("wd_idle",    4'b0000, 8'hE4, 1'b0, {1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000});
        step("wd_regrant", 4'b1010, 8'hE4, 1'b0, {1'b1, 4'b0010, 2'd1, 2'd1, 4'b0000});

        // Handshake and withdrawal together: pulse issued, pointer moves past m1.
        step("sim_hs",     4'b1000, 8'hE4, 1'b1, {1'b0, 4'b0000, 2'd0, 2'd0, 4'b0010});
        step("sim_settle", 4'b1011, 8'hE4, 1'b0, {1'b0, 4'b0000, 2'd0, 2'd0, 4'b0000});
        step("sim_next",   4'b1011, 8'hE4, 1'b0, {1'b1, 4'b1000, 2'd3, 2'd3, 4'b0000});

        // Reset mid-grant clears outputs asynchronously and restores the pointer.
        do_reset();
        step("rst_m2", 4'b0100, 8'hE4, 1'b0, {1'b1, 4'b0100, 2'd2, 2'd2, 4'b0000});
        #2;
        sysReset = 1'b0;
        #1;
        check("rst_async", 13'h0000);
        @(posedge sysClk);
        #1;
        check("rst_held", 13'h0000);
        sysReset = 1'b1;
        step("rst_after", 4'b0110, 8'hE4, 1'b0, {1'b1, 4'b0010, 2'd1, 2'd1, 4'b0000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
